// File: rtl/flash_phy_pkg.sv
// Shared types and geometry for the flash PHY responder: FSM states, operation
// codes, default address widths and small elaboration-time helpers.
package flash_phy_pkg;

  localparam int FLASH_BKW = 1;
  localparam int FLASH_PGW = 8;
  localparam int FLASH_WDW = 8;

  typedef enum logic [3:0] {
    StInit,
    StIdle,
    StRdWait,
    StRdMem,
    StRdDone,
    StPgRd,
    StPgWr,
    StPgBusy,
    StErSweep,
    StErBusy,
    StAck
  } state_e;

  typedef enum logic [1:0] {
    OpRd,
    OpProg,
    OpPgErase,
    OpBkErase
  } op_e;

  // Priority rd > prog > pg_erase > bk_erase; caller qualifies with "any op bit set".
  function automatic op_e op_select(input logic rd, input logic prog, input logic pg_erase);
    if (rd) return OpRd;
    else if (prog) return OpProg;
    else if (pg_erase) return OpPgErase;
    else return OpBkErase;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flash_phy_timer.sv
// Loadable down-counter shared by all timed waits; done is high while the count is zero.
// The reset value lets the post-reset init wait run without an explicit load.
module flash_phy_timer #(
  parameter int              CntW   = 8,
  parameter logic [CntW-1:0] RstVal = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic            done
);

  logic [CntW-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= RstVal;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/flash_phy_resp.sv
// Flash-timing emulator over a single-port SRAM: timed reads, AND-only programs,
// page/bank erase sweeps, and init-busy signalling after reset.
module flash_phy_resp
  import flash_phy_pkg::*;
#(
  parameter int BankW       = FLASH_BKW,
  parameter int PageW       = FLASH_PGW,
  parameter int WordW       = FLASH_WDW,
  parameter int DataW       = 32,
  parameter int ReadCycles  = 2,
  parameter int ProgCycles  = 10,
  parameter int EraseCycles = 20,
  parameter int InitCycles  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  input  logic                         rd_i,
  input  logic                         prog_i,
  input  logic                         pg_erase_i,
  input  logic                         bk_erase_i,
  input  logic [BankW+PageW+WordW-1:0] addr_i,
  input  logic [DataW-1:0]             prog_data_i,
  output logic                         rd_done_o,
  output logic                         prog_done_o,
  output logic                         erase_done_o,
  output logic [DataW-1:0]             rd_data_o,
  output logic                         init_busy_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [BankW+PageW+WordW-1:0] mem_addr_o,
  output logic [DataW-1:0]             mem_wdata_o,
  input  logic [DataW-1:0]             mem_rdata_i
);

  localparam int AddrW     = BankW + PageW + WordW;
  localparam int BankWords = 1 << (PageW + WordW);
  localparam int MaxCnt    = max_int(max_int(max_int(ReadCycles, ProgCycles),
                                             max_int(EraseCycles, InitCycles)), BankWords);
  localparam int CntW      = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] ReadLoad  = CntW'(ReadCycles - 1);
  localparam logic [CntW-1:0] ProgLoad  = CntW'(ProgCycles - 1);
  localparam logic [CntW-1:0] EraseLoad = CntW'(EraseCycles - 1);
  localparam logic [CntW-1:0] InitLoad  = CntW'(InitCycles - 1);
  localparam logic [CntW-1:0] PageLast  = CntW'((1 << WordW) - 1);
  localparam logic [CntW-1:0] BankLast  = CntW'(BankWords - 1);

  state_e           state_reg, state_next;
  op_e              op_reg;
  logic [AddrW-1:0] addr_reg;
  logic [DataW-1:0] data_reg;
  logic [CntW-1:0]  sweep_reg, sweep_next;
  logic [DataW-1:0] rd_data_reg;
  logic             rd_done_reg, prog_done_reg, erase_done_reg;

  logic             capture, set_rd, set_prog, set_erase;
  logic             tmr_load, tmr_done;
  logic [CntW-1:0]  tmr_val;
  op_e              op_sel;
  logic             op_valid;
  logic [AddrW-1:0] sweep_base;
  logic [CntW-1:0]  sweep_last;

  flash_phy_timer #(
    .CntW  (CntW),
    .RstVal(InitLoad)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  assign op_sel   = op_select(rd_i, prog_i, pg_erase_i);
  assign op_valid = rd_i | prog_i | pg_erase_i | bk_erase_i;

  always_comb begin
    sweep_base = '0;
    sweep_last = BankLast;
    if (op_reg == OpPgErase) begin
      sweep_base = {addr_reg[AddrW-1:WordW], {WordW{1'b0}}};
      sweep_last = PageLast;
    end else begin
      sweep_base = {addr_reg[AddrW-1:AddrW-BankW], {(PageW + WordW){1'b0}}};
    end
  end

  always_comb begin
    state_next  = state_reg;
    sweep_next  = sweep_reg;
    capture     = 1'b0;
    set_rd      = 1'b0;
    set_prog    = 1'b0;
    set_erase   = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_reg)
      StInit: if (tmr_done) state_next = StIdle;
      StIdle: begin
        if (req_i && op_valid) begin
          capture = 1'b1;
          case (op_sel)
            OpRd: begin
              tmr_load   = 1'b1;
              tmr_val    = ReadLoad;
              state_next = StRdWait;
            end
            OpProg:  state_next = StPgRd;
            default: begin
              sweep_next = '0;
              state_next = StErSweep;
            end
          endcase
        end
      end
      StRdWait: if (tmr_done) state_next = StRdMem;
      StRdMem: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_reg;
        state_next = StRdDone;
      end
      StRdDone: begin
        set_rd     = 1'b1;
        state_next = StAck;
      end
      StPgRd: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_reg;
        state_next = StPgWr;
      end
      StPgWr: begin
        // Flash programming can only pull bits low.
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_reg;
        mem_wdata_o = mem_rdata_i & data_reg;
        tmr_load    = 1'b1;
        tmr_val     = ProgLoad;
        state_next  = StPgBusy;
      end
      StPgBusy: begin
        if (tmr_done) begin
          set_prog   = 1'b1;
          state_next = StAck;
        end
      end
      StErSweep: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = sweep_base | AddrW'(sweep_reg);
        mem_wdata_o = '1;
        if (sweep_reg == sweep_last) begin
          tmr_load   = 1'b1;
          tmr_val    = EraseLoad;
          state_next = StErBusy;
        end else begin
          sweep_next = sweep_reg + 1'b1;
        end
      end
      StErBusy: begin
        if (tmr_done) begin
          set_erase  = 1'b1;
          state_next = StAck;
        end
      end
      StAck:   state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= StInit;
      op_reg         <= OpRd;
      addr_reg       <= '0;
      data_reg       <= '0;
      sweep_reg      <= '0;
      rd_data_reg    <= '0;
      rd_done_reg    <= 1'b0;
      prog_done_reg  <= 1'b0;
      erase_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sweep_reg      <= sweep_next;
      rd_done_reg    <= set_rd;
      prog_done_reg  <= set_prog;
      erase_done_reg <= set_erase;
      if (capture) begin
        op_reg   <= op_sel;
        addr_reg <= addr_i;
        data_reg <= prog_data_i;
      end
      if (set_rd) rd_data_reg <= mem_rdata_i;
    end
  end

  assign rd_done_o    = rd_done_reg;
  assign prog_done_o  = prog_done_reg;
  assign erase_done_o = erase_done_reg;
  assign rd_data_o    = rd_data_reg;
  assign init_busy_o  = (state_reg == StInit);

endmodule

// File: tb/tb_flash_phy_resp.sv
// Directed bench for flash_phy_resp: command vector table against an SRAM model,
// plus hand-written init and reset-during-erase sequences.
module tb_flash_phy_resp;

  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, rd = 1'b0, prog = 1'b0, pg_erase = 1'b0, bk_erase = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] prog_data = '0;
  logic          rd_done, prog_done, erase_done, init_busy;
  logic [DW-1:0] rd_data;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            wr_commits = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_phy_resp dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .rd_i        (rd),
    .prog_i      (prog),
    .pg_erase_i  (pg_erase),
    .bk_erase_i  (bk_erase),
    .addr_i      (addr),
    .prog_data_i (prog_data),
    .rd_done_o   (rd_done),
    .prog_done_o (prog_done),
    .erase_done_o(erase_done),
    .rd_data_o   (rd_data),
    .init_busy_o (init_busy),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Single-port SRAM with registered read data.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_commits    = wr_commits + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    logic [3:0]    ops;       // {rd, prog, pg_erase, bk_erase}
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            limit;
    logic [2:0]    exp_done;  // {rd_done, prog_done, erase_done}
    int            exp_lat;   // capture->done for rd/prog, last write->done for erase
    logic [DW-1:0] exp_rdata;
    int            exp_nwr;
    logic [AW-1:0] exp_lo;
    logic [AW-1:0] exp_hi;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  vec_t vecs [13];

  logic [2:0]    res_kind;
  int            res_lat, res_gap, res_nwr, res_extra;
  logic [DW-1:0] res_rdata, res_wd;
  logic [AW-1:0] res_lo, res_hi;
  logic          res_allones;
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int last_wr;
    res_kind = '0; res_lat = -1; res_gap = -1; res_nwr = 0; res_extra = 0;
    res_rdata = '0; res_wd = '0; res_lo = '1; res_hi = '0; res_allones = 1'b1;
    last_wr = 0;
    {rd, prog, pg_erase, bk_erase} = v.ops;
    addr = v.addr; prog_data = v.data; req = 1'b1;
    for (int k = 1; k <= v.limit; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Operands must have been captured; scramble them to prove it.
        addr = ~v.addr; prog_data = ~v.data; {rd, prog, pg_erase, bk_erase} = 4'b0;
      end
      if (mem_req && mem_we) begin
        res_nwr++;
        if (mem_addr < res_lo) res_lo = mem_addr;
        if (mem_addr > res_hi) res_hi = mem_addr;
        res_wd = mem_wdata;
        if (mem_wdata !== '1) res_allones = 1'b0;
        last_wr = k;
      end
      if (rd_done || prog_done || erase_done) begin
        res_kind  = {rd_done, prog_done, erase_done};
        res_lat   = k - 1;
        res_gap   = k - last_wr;
        res_rdata = rd_data;
        break;
      end
    end
    // Keep req high across the acknowledge edge, then drop it and watch for a re-capture.
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (mem_req || rd_done || prog_done || erase_done) res_extra++;
      @(negedge clk);
    end
  endtask

  task automatic wait_init(input string name, output int n);
    n = 0;
    while (init_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, bad, activity, base;
    vec_t rv;

    for (int i = 0; i < (1 << AW); i++) mem[i] = (i >= 'h10000) ? 32'h55AA_55AA : 32'hFFFF_FFFF;
    for (int i = 'h200; i <= 'h2FF; i++) mem[i] = 32'h0;
    mem['h00300] = 32'hA5A5_0300;
    mem['h0FFFF] = 32'h1234_5678;
    mem['h00010] = 32'hCAFE_0010;

    //            ops      addr       data          lim    done    lat rdata          nwr    lo         hi         wdata
    vecs[0]  = '{4'b0100, 17'h00105, 32'h0F0F_00FF, 30,    3'b010, 12, 32'h0,         1,     17'h00105, 17'h00105, 32'h0F0F_00FF};
    vecs[1]  = '{4'b0100, 17'h00105, 32'hFF00_FFFF, 30,    3'b010, 12, 32'h0,         1,     17'h00105, 17'h00105, 32'h0F00_00FF};
    vecs[2]  = '{4'b1000, 17'h00105, 32'h0,         20,    3'b100, 4,  32'h0F00_00FF, 0,     17'h0,     17'h0,     32'h0};
    vecs[3]  = '{4'b1100, 17'h00105, 32'h0,         20,    3'b100, 4,  32'h0F00_00FF, 0,     17'h0,     17'h0,     32'h0};
    vecs[4]  = '{4'b0011, 17'h00237, 32'h0,         400,   3'b001, 21, 32'h0,         256,   17'h00200, 17'h002FF, 32'hFFFF_FFFF};
    vecs[5]  = '{4'b1000, 17'h00300, 32'h0,         20,    3'b100, 4,  32'hA5A5_0300, 0,     17'h0,     17'h0,     32'h0};
    vecs[6]  = '{4'b1000, 17'h002AA, 32'h0,         20,    3'b100, 4,  32'hFFFF_FFFF, 0,     17'h0,     17'h0,     32'h0};
    vecs[7]  = '{4'b0110, 17'h00300, 32'h0000_FFFF, 30,    3'b010, 12, 32'h0,         1,     17'h00300, 17'h00300, 32'h0000_0300};
    vecs[8]  = '{4'b1000, 17'h00300, 32'h0,         20,    3'b100, 4,  32'h0000_0300, 0,     17'h0,     17'h0,     32'h0};
    vecs[9]  = '{4'b0000, 17'h00105, 32'h0,         10,    3'b000, 0,  32'h0,         0,     17'h0,     17'h0,     32'h0};
    vecs[10] = '{4'b0001, 17'h1ABCD, 32'h0,         66000, 3'b001, 21, 32'h0,         65536, 17'h10000, 17'h1FFFF, 32'hFFFF_FFFF};
    vecs[11] = '{4'b1000, 17'h0FFFF, 32'h0,         20,    3'b100, 4,  32'h1234_5678, 0,     17'h0,     17'h0,     32'h0};
    vecs[12] = '{4'b1000, 17'h1ABCD, 32'h0,         20,    3'b100, 4,  32'hFFFF_FFFF, 0,     17'h0,     17'h0,     32'h0};

    // Reset state, then a read request held during init must be ignored.
    req = 1'b1; rd = 1'b1; addr = 17'h00010;
    repeat (3) @(negedge clk);
    check("reset_flags", 64'({mem_req, mem_we, rd_done, prog_done, erase_done, init_busy}), 64'(6'b000001));
    check("reset_rd_data", 64'(rd_data), 64'h0);
    check("reset_mem_addr", 64'(mem_addr), 64'h0);
    rst_n = 1'b1;
    n = 0; activity = 0;
    while (init_busy && n < 100) begin
      n++;
      if (mem_req || rd_done || prog_done || erase_done) activity++;
      @(negedge clk);
    end
    req = 1'b0; rd = 1'b0; addr = '0;
    check("init_busy_cycles", 64'(n), 64'd16);
    check("init_req_ignored", 64'(activity), 64'd0);
    $display("init: busy for %0d cycles, activity %0d", n, activity);

    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i]);
      $display("vec %0d: ops=%b addr=%h done=%b lat=%0d gap=%0d nwr=%0d rdata=%h",
               i, vecs[i].ops, vecs[i].addr, res_kind, res_lat, res_gap, res_nwr, res_rdata);
      check($sformatf("v%0d_done_kind", i), 64'(res_kind), 64'(vecs[i].exp_done));
      if (vecs[i].exp_done[0])
        check($sformatf("v%0d_gap_last_write_to_done", i), 64'(res_gap), 64'(vecs[i].exp_lat));
      else if (vecs[i].exp_done != 3'b000)
        check($sformatf("v%0d_latency", i), 64'(res_lat), 64'(vecs[i].exp_lat));
      if (vecs[i].exp_done[2]) begin
        check($sformatf("v%0d_rd_data", i), 64'(res_rdata), 64'(vecs[i].exp_rdata));
        last_rd = vecs[i].exp_rdata;
      end else begin
        check($sformatf("v%0d_rd_data_held", i), 64'(rd_data), 64'(last_rd));
      end
      check($sformatf("v%0d_write_count", i), 64'(res_nwr), 64'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr > 0) begin
        check($sformatf("v%0d_write_lo", i), 64'(res_lo), 64'(vecs[i].exp_lo));
        check($sformatf("v%0d_write_hi", i), 64'(res_hi), 64'(vecs[i].exp_hi));
        check($sformatf("v%0d_write_data", i), 64'(res_wd), 64'(vecs[i].exp_wdata));
        if (vecs[i].exp_done[0])
          check($sformatf("v%0d_erase_all_ones", i), 64'(res_allones), 64'd1);
      end
      check($sformatf("v%0d_no_recapture", i), 64'(res_extra), 64'd0);
    end
    check("prog_result_in_array", 64'(mem['h00105]), 64'h0F00_00FF);
    check("bank0_word_kept", 64'(mem['h0FFFF]), 64'h1234_5678);

    // Reset in the middle of a bank erase, after exactly 100 committed writes.
    for (int i = 'h10000; i <= 'h10063; i++) mem[i] = 32'h0;
    mem['h10064] = 32'h600D_F00D;
    base = wr_commits;
    bk_erase = 1'b1; addr = 17'h10000; req = 1'b1;
    n = 0;
    while ((wr_commits - base) < 100 && n < 500) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_commits", 64'(wr_commits - base), 64'd100);
    check("midrst_flags", 64'({mem_req, mem_we, rd_done, prog_done, erase_done, init_busy}), 64'(6'b000001));
    check("midrst_rd_data", 64'(rd_data), 64'h0);
    check("midrst_mem_addr", 64'(mem_addr), 64'h0);
    check("midrst_mem_wdata", 64'(mem_wdata), 64'h0);
    bad = 0;
    for (int i = 'h10000; i <= 'h10063; i++) if (mem[i] !== 32'hFFFF_FFFF) bad++;
    check("midrst_prefix_erased", 64'(bad), 64'd0);
    check("midrst_next_word_kept", 64'(mem['h10064]), 64'h600D_F00D);
    $display("midrst: %0d writes committed before reset", wr_commits - base);
    req = 1'b0; bk_erase = 1'b0; addr = '0;
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit", n);
    check("reinit_busy_cycles", 64'(n), 64'd16);

    rv = '{4'b1000, 17'h10064, 32'h0, 20, 3'b100, 4, 32'h600D_F00D, 0, 17'h0, 17'h0, 32'h0};
    run_cmd(rv);
    $display("post-reset read: addr=%h done=%b lat=%0d rdata=%h", rv.addr, res_kind, res_lat, res_rdata);
    check("postrst_done_kind", 64'(res_kind), 64'(3'b100));
    check("postrst_rd_data", 64'(res_rdata), 64'h600D_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
